// File: rtl/matrix_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : matrix_pkg
//  Purpose  : Shared mode encoding and default geometry for the LED matrix
//             frame scanner.
//  Revision : 1.0  initial release
// ============================================================================
package matrix_pkg;

    typedef enum logic [1:0] {
        MODE_STATIC  = 2'b00,
        MODE_LOOP    = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_e;

    localparam int DEF_N_COLS   = 5;
    localparam int DEF_N_ROWS   = 7;
    localparam int DEF_N_FRAMES = 8;

    // The reserved encoding behaves exactly like STATIC.
    function automatic mode_e norm_mode(input logic [1:0] m);
        case (m)
            2'b01:   return MODE_LOOP;
            2'b10:   return MODE_ONESHOT;
            default: return MODE_STATIC;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_frame_scanner_if.sv
`default_nettype none
// ============================================================================
//  Module   : matrix_frame_scanner_if
//  Purpose  : Control, frame-ROM and matrix-pin bundle of the frame scanner.
//  Revision : 1.0  initial release
// ============================================================================
interface matrix_frame_scanner_if #(
    parameter int N_COLS   = 5,
    parameter int N_ROWS   = 7,
    parameter int N_FRAMES = 8
);
    localparam int RW = (N_ROWS   > 1) ? $clog2(N_ROWS)   : 1;
    localparam int FW = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1;

    logic              enable;
    logic [1:0]        mode;
    logic [FW-1:0]     frame_sel;
    logic              restart;
    logic [FW-1:0]     rom_frame;
    logic [RW-1:0]     rom_row;
    logic [N_COLS-1:0] rom_cols;
    logic [N_COLS-1:0] colunas;
    logic [N_ROWS-1:0] linhas;
    logic              scan_wrap;
    logic              done;

    modport master (
        output enable, mode, frame_sel, restart, rom_cols,
        input  rom_frame, rom_row, colunas, linhas, scan_wrap, done
    );

    modport slave (
        input  enable, mode, frame_sel, restart, rom_cols,
        output rom_frame, rom_row, colunas, linhas, scan_wrap, done
    );

endinterface
`default_nettype wire

// File: rtl/matrix_frame_scanner_tick_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tick_divider
//  Purpose  : Row-slot divider; pulses tick once every SCAN_DIV enabled clocks.
//  Revision : 1.0  initial release
// ============================================================================
module tick_divider #(
    parameter int SCAN_DIV = 1000
) (
    input  wire logic clock,
    input  wire logic reset,
    input  wire logic enable,
    input  wire logic clear,
    output logic      tick
);
    localparam int             DW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0]  c_last = DW'(SCAN_DIV - 1);

    logic [DW-1:0] div_cnt_q;
    logic [DW-1:0] div_cnt_d;

    // clear suppresses the tick so a restart always wins over a coincident slot end
    assign tick = enable && !clear && (div_cnt_q == c_last);

    always_comb begin
        div_cnt_d = div_cnt_q;
        if (clear) begin
            div_cnt_d = '0;
        end else if (enable) begin
            div_cnt_d = (div_cnt_q == c_last) ? '0 : div_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/matrix_frame_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : matrix_frame_scanner
//  Purpose  : Row-multiplexed LED matrix driver with static, looping and
//             one-shot frame animation fed from an external frame ROM.
//  Options  : ROW_BLANKING_EN - one all-off clock on every row tick.
//  Revision : 1.0  initial release
// ============================================================================
module matrix_frame_scanner
    import matrix_pkg::*;
#(
    parameter int N_COLS     = DEF_N_COLS,
    parameter int N_ROWS     = DEF_N_ROWS,
    parameter int N_FRAMES   = DEF_N_FRAMES,
    parameter int SCAN_DIV   = 1000,
    parameter int FRAME_HOLD = 50
) (
    input  wire logic               clock,
    input  wire logic               reset,
    matrix_frame_scanner_if.slave   bus
);
    localparam int RW = (N_ROWS     > 1) ? $clog2(N_ROWS)     : 1;
    localparam int FW = (N_FRAMES   > 1) ? $clog2(N_FRAMES)   : 1;
    localparam int HW = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

    localparam logic [RW-1:0] c_last_row   = RW'(N_ROWS - 1);
    localparam logic [FW-1:0] c_last_frame = FW'(N_FRAMES - 1);
    localparam logic [HW-1:0] c_last_hold  = HW'(FRAME_HOLD - 1);

    logic              w_tick;
    logic              w_wrap;
    mode_e             w_mode_in;
    logic [N_ROWS-1:0] w_row_onehot;

    logic [RW-1:0]     row_idx_q,   row_idx_d;
    logic [FW-1:0]     frame_idx_q, frame_idx_d;
    logic [HW-1:0]     hold_cnt_q,  hold_cnt_d;
    mode_e             mode_q,      mode_d;
    logic              done_q,      done_d;
    logic              scan_wrap_q, scan_wrap_d;
    logic [N_COLS-1:0] colunas_q,   colunas_d;
    logic [N_ROWS-1:0] linhas_q,    linhas_d;
`ifdef ROW_BLANKING_EN
    logic              blank_q,     blank_d;
`endif

    tick_divider #(
        .SCAN_DIV (SCAN_DIV)
    ) u_tick_divider (
        .clock  (clock),
        .reset  (reset),
        .enable (bus.enable),
        .clear  (bus.restart),
        .tick   (w_tick)
    );

    assign w_wrap       = w_tick && (row_idx_q == c_last_row);
    assign w_mode_in    = norm_mode(bus.mode);
    assign w_row_onehot = N_ROWS'(1) << row_idx_q;

    // Row, frame and hold sequencing; frames only ever change on a scan wrap.
    always_comb begin
        row_idx_d   = row_idx_q;
        frame_idx_d = frame_idx_q;
        hold_cnt_d  = hold_cnt_q;
        mode_d      = mode_q;
        done_d      = done_q;
        scan_wrap_d = 1'b0;

        if (bus.restart) begin
            row_idx_d   = '0;
            hold_cnt_d  = '0;
            done_d      = 1'b0;
            frame_idx_d = bus.frame_sel;
            mode_d      = w_mode_in;
        end else if (w_tick) begin
            row_idx_d   = w_wrap ? '0 : row_idx_q + 1'b1;
            scan_wrap_d = w_wrap;
            if (w_wrap) begin
                if (w_mode_in != mode_q) begin
                    mode_d      = w_mode_in;
                    hold_cnt_d  = '0;
                    done_d      = 1'b0;
                    frame_idx_d = bus.frame_sel;
                end else if (mode_q == MODE_STATIC) begin
                    frame_idx_d = bus.frame_sel;
                end else if (hold_cnt_q == c_last_hold) begin
                    hold_cnt_d = '0;
                    if (frame_idx_q != c_last_frame) begin
                        frame_idx_d = frame_idx_q + 1'b1;
                    end else if (mode_q == MODE_ONESHOT) begin
                        done_d = 1'b1;
                    end else begin
                        frame_idx_d = '0;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
        end
    end

    // Pin register: columns and row select come from the same row_idx sample,
    // so they can never drift apart.
    always_comb begin
        colunas_d = '0;
        linhas_d  = '1;
`ifdef ROW_BLANKING_EN
        blank_d   = 1'b0;
        if (bus.enable) begin
            blank_d = w_tick;
            if (!blank_q) begin
                colunas_d = bus.rom_cols;
                linhas_d  = ~w_row_onehot;
            end
        end
`else
        if (bus.enable) begin
            colunas_d = bus.rom_cols;
            linhas_d  = ~w_row_onehot;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            row_idx_q   <= '0;
            frame_idx_q <= '0;
            hold_cnt_q  <= '0;
            mode_q      <= MODE_STATIC;
            done_q      <= 1'b0;
            scan_wrap_q <= 1'b0;
            colunas_q   <= '0;
            linhas_q    <= '1;
`ifdef ROW_BLANKING_EN
            blank_q     <= 1'b0;
`endif
        end else begin
            row_idx_q   <= row_idx_d;
            frame_idx_q <= frame_idx_d;
            hold_cnt_q  <= hold_cnt_d;
            mode_q      <= mode_d;
            done_q      <= done_d;
            scan_wrap_q <= scan_wrap_d;
            colunas_q   <= colunas_d;
            linhas_q    <= linhas_d;
`ifdef ROW_BLANKING_EN
            blank_q     <= blank_d;
`endif
        end
    end

    assign bus.rom_frame = frame_idx_q;
    assign bus.rom_row   = row_idx_q;
    assign bus.colunas   = colunas_q;
    assign bus.linhas    = linhas_q;
    assign bus.scan_wrap = scan_wrap_q;
    assign bus.done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_matrix_frame_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_matrix_frame_scanner
//  Purpose  : Self-checking bench for matrix_frame_scanner (7x5, 8 frames,
//             SCAN_DIV=4, FRAME_HOLD=2, ROM = {frame[1:0], row[2:0]}).
//  Revision : 1.0  initial release
// ============================================================================
module tb_matrix_frame_scanner;
    import matrix_pkg::*;

    localparam int SCAN_DIV   = 4;
    localparam int FRAME_HOLD = 2;
    localparam int SCAN_LEN   = 7 * SCAN_DIV;
`ifdef ROW_BLANKING_EN
    localparam int BLANK = 1;
`else
    localparam int BLANK = 0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;

    matrix_frame_scanner_if #(.N_COLS(5), .N_ROWS(7), .N_FRAMES(8)) bus ();

    matrix_frame_scanner #(
        .N_COLS     (5),
        .N_ROWS     (7),
        .N_FRAMES   (8),
        .SCAN_DIV   (SCAN_DIV),
        .FRAME_HOLD (FRAME_HOLD)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.rom_cols = {bus.rom_frame[1:0], bus.rom_row};

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic [11:0] exp_q[$];
    logic [11:0] prev_pair;
    bit          prev_valid;
    bit          have_last;
    int          last_chg;
    bit          wrap_seen;
    int          last_wrap;
    int          blanks;

    function automatic logic [11:0] exp_pair(input int f, input int r);
        logic [2:0] fb;
        logic [2:0] rb;
        logic [6:0] one;
        fb  = 3'(f);
        rb  = 3'(r);
        one = 7'd1;
        return {~(one << rb), fb[1:0], rb};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_rows(input int f, input int r0, input int r1);
        for (int r = r0; r <= r1; r++) exp_q.push_back(exp_pair(f, r));
    endtask

    task automatic do_restart(input int f, input logic [1:0] m);
        bus.frame_sel = 3'(f);
        bus.mode      = m;
        bus.restart   = 1'b1;
        step();
        bus.restart   = 1'b0;
        prev_valid = 1'b0;
        have_last  = 1'b0;
        wrap_seen  = 1'b0;
        blanks     = 0;
    endtask

    // Scoreboard monitor: each new row shown on the pins is popped and compared.
    task automatic run(input int n);
        logic [11:0] pair;
        logic [11:0] e;
        for (int i = 0; i < n; i++) begin
            step();
            pair = {bus.linhas, bus.colunas};
            if (bus.scan_wrap) begin
                if (wrap_seen) begin
                    total++;
                    if (cyc - last_wrap !== SCAN_LEN) begin
                        bad++;
                        $display("FAIL wrap_period: got %0d want %0d", cyc - last_wrap, SCAN_LEN);
                    end
                end
                wrap_seen = 1'b1;
                last_wrap = cyc;
            end
            if (bus.linhas === 7'h7F) begin
                blanks++;
                total++;
                if (bus.colunas !== 5'd0) begin
                    bad++;
                    $display("FAIL blank_cols: got %b want 00000", bus.colunas);
                end
            end else if (!prev_valid || pair !== prev_pair) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_row: got %h want none", pair);
                end else begin
                    e = exp_q.pop_front();
                    if (pair !== e) begin
                        bad++;
                        $display("FAIL row_data: got %h want %h at cyc %0d", pair, e, cyc);
                    end
                end
                if (have_last) begin
                    total++;
                    if (cyc - last_chg !== SCAN_DIV) begin
                        bad++;
                        $display("FAIL row_period: got %0d want %0d", cyc - last_chg, SCAN_DIV);
                    end
                end
                have_last  = 1'b1;
                last_chg   = cyc;
                prev_pair  = pair;
                prev_valid = 1'b1;
            end
        end
    endtask

    task automatic check_leftover(input string tag);
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("FAIL %s_leftover: got %0d rows pending want 0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        bus.enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (bus.colunas !== 5'd0 || bus.linhas !== 7'h7F || bus.rom_row !== 3'd0 || bus.done !== 1'b0) begin
                bad++;
                $display("FAIL reset_state: got cols=%b lin=%h row=%0d done=%b want 00000/7f/0/0",
                         bus.colunas, bus.linhas, bus.rom_row, bus.done);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_static();
        do_restart(3, MODE_STATIC);
        push_rows(3, 0, 6);
        push_rows(3, 0, 6);
        run(2 * SCAN_LEN);
        check_leftover("static");
        total++;
        if (blanks !== 13 * BLANK) begin
            bad++;
            $display("FAIL static_blanks: got %0d want %0d", blanks, 13 * BLANK);
        end
    endtask

    task automatic test_frame_change();
        do_restart(3, MODE_STATIC);
        push_rows(3, 0, 6);
        push_rows(5, 0, 6);
        run(8);
        bus.frame_sel = 3'd5;
        run(SCAN_LEN - 9);
        total++;
        if (bus.rom_frame !== 3'd3) begin
            bad++;
            $display("FAIL static_no_tear: got frame %0d want 3", bus.rom_frame);
        end
        run(1);
        total++;
        if (bus.rom_frame !== 3'd5) begin
            bad++;
            $display("FAIL static_new_frame: got frame %0d want 5", bus.rom_frame);
        end
        run(SCAN_LEN);
        check_leftover("frame_change");
    endtask

    task automatic test_loop();
        do_restart(6, MODE_LOOP);
        push_rows(6, 0, 6); push_rows(6, 0, 6);
        push_rows(7, 0, 6); push_rows(7, 0, 6);
        push_rows(0, 0, 6); push_rows(0, 0, 6);
        run(6 * SCAN_LEN);
        check_leftover("loop");
        total++;
        if (bus.rom_frame !== 3'd1 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL loop_end: got frame=%0d done=%b want 1/0", bus.rom_frame, bus.done);
        end
    endtask

    task automatic test_oneshot();
        do_restart(6, MODE_ONESHOT);
        push_rows(6, 0, 6); push_rows(6, 0, 6);
        push_rows(7, 0, 6); push_rows(7, 0, 6);
        run(4 * SCAN_LEN - 1);
        total++;
        if (bus.done !== 1'b0) begin
            bad++;
            $display("FAIL oneshot_early_done: got %b want 0", bus.done);
        end
        run(1);
        total++;
        if (bus.done !== 1'b1 || bus.rom_frame !== 3'd7) begin
            bad++;
            $display("FAIL oneshot_done: got done=%b frame=%0d want 1/7", bus.done, bus.rom_frame);
        end
        push_rows(7, 0, 6);
        run(SCAN_LEN);
        check_leftover("oneshot");
        total++;
        if (bus.done !== 1'b1 || bus.rom_frame !== 3'd7) begin
            bad++;
            $display("FAIL oneshot_sticky: got done=%b frame=%0d want 1/7", bus.done, bus.rom_frame);
        end
        do_restart(2, MODE_ONESHOT);
        total++;
        if (bus.done !== 1'b0 || bus.rom_frame !== 3'd2) begin
            bad++;
            $display("FAIL oneshot_restart: got done=%b frame=%0d want 0/2", bus.done, bus.rom_frame);
        end
    endtask

    task automatic test_enable();
        int  k;
        bit  found;
        do_restart(4, MODE_STATIC);
        push_rows(4, 0, 4);
        run(4 * SCAN_DIV + 1 + BLANK);
        check_leftover("enable_pre");
        bus.enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            total++;
            if (bus.linhas !== 7'h7F || bus.colunas !== 5'd0 || bus.rom_row !== 3'd4) begin
                bad++;
                $display("FAIL disabled_hold: got lin=%h cols=%b row=%0d want 7f/00000/4",
                         bus.linhas, bus.colunas, bus.rom_row);
            end
        end
        bus.enable = 1'b1;
        k = 0;
        found = 1'b0;
        while (k < 10 && !found) begin
            step();
            k++;
            if (bus.linhas === 7'h5F) found = 1'b1;
        end
        total++;
        if (!found || k !== 4 || {bus.linhas, bus.colunas} !== exp_pair(4, 5)) begin
            bad++;
            $display("FAIL resume_row5: got found=%b steps=%0d pins=%h want 1/4/%h",
                     found, k, {bus.linhas, bus.colunas}, exp_pair(4, 5));
        end
        prev_pair  = {bus.linhas, bus.colunas};
        prev_valid = 1'b1;
        have_last  = 1'b1;
        last_chg   = cyc;
        push_rows(4, 6, 6);
        push_rows(4, 0, 1);
        run(3 * SCAN_DIV);
        check_leftover("enable_post");
    endtask

    task automatic test_reset_mid();
        run(2);
        reset = 1'b1;
        step();
        total++;
        if (bus.linhas !== 7'h7F || bus.colunas !== 5'd0 || bus.rom_row !== 3'd0) begin
            bad++;
            $display("FAIL reset_mid: got lin=%h cols=%b row=%0d want 7f/00000/0",
                     bus.linhas, bus.colunas, bus.rom_row);
        end
        reset = 1'b0;
    endtask

    initial begin
        bus.enable    = 1'b0;
        bus.mode      = MODE_STATIC;
        bus.frame_sel = 3'd0;
        bus.restart   = 1'b0;
        prev_valid    = 1'b0;
        have_last     = 1'b0;
        wrap_seen     = 1'b0;
        last_chg      = 0;
        last_wrap     = 0;
        blanks        = 0;
        prev_pair     = '0;
        test_reset();
        test_static();
        test_frame_change();
        test_loop();
        test_oneshot();
        test_enable();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
